// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid register stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg_enable_reg.sv
// WIDTH-wide load-enable register with async active-low reset and sync flush.
module enable_reg #(
    parameter int unsigned           WIDTH     = 64,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             softReset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // A flush wins over a load so a payload offered during softReset is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= RESET_VAL;
        end else if (softReset) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage with a 2-entry skid buffer; all outputs come
// straight from registers so neither side sees a combinational path.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             softReset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state_q, state_d;
    logic             fire_in, fire_out;
    logic             main_en, main_from_skid, skid_en;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign fire_in  = in_valid & in_ready;
    assign fire_out = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (fire_in) begin
                    state_d = BUSY;
                    main_en = 1'b1;
                end
            end
            BUSY: begin
                if (fire_in && fire_out) begin
                    main_en = 1'b1;
                end else if (fire_in) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (fire_out) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so the only move is draining skid into main.
                if (fire_out) begin
                    state_d        = BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (softReset) begin
            state_d = EMPTY;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    enable_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk       (clk),
        .reset     (reset),
        .softReset (softReset),
        .en_i      (main_en),
        .d_i       (main_d),
        .q_o       (main_q)
    );

    enable_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .softReset (softReset),
        .en_i      (skid_en),
        .d_i       (in_data),
        .q_o       (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table, async-reset sequence and random scoreboard for pipe_skid_reg.
module tb_pipe_skid_reg;

    localparam int unsigned      W  = 64;
    localparam logic [W-1:0]     RV = 64'h5A5A_0000_C0DE_0001;

    logic         clk = 1'b0;
    logic         reset;
    logic         softReset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .softReset (softReset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         sr;
        logic         ev;
        logic         er;
        logic [W-1:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic sr, input logic ev, input logic er,
                       input logic [W-1:0] ed);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.sr = sr;
        v.ev = ev; v.er = er; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] sb[$];
    logic         prev_stall;
    logic [W-1:0] prev_data;

    initial begin
        reset     = 1'b0;
        softReset = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_data",  out_data, RV);
        reset = 1'b1;
        tick();
        $display("reset: out_valid=%0b in_ready=%0b out_data=%h", out_valid, in_ready, out_data);

        // Streaming 1..8 with out_ready high, then drain
        for (int i = 1; i <= 8; i++) add(1, W'(i), 1, 0, 1, 1, W'(i));
        add(0, 0, 1, 0, 0, 1, 64'h8);
        // Backpressure A, B (C refused while FULL), then drain
        add(1, 64'hA, 0, 0, 1, 1, 64'hA);
        add(1, 64'hB, 0, 0, 1, 0, 64'hA);
        add(1, 64'hC, 0, 0, 1, 0, 64'hA);
        add(0, 0,     1, 0, 1, 1, 64'hB);
        add(0, 0,     1, 0, 0, 1, 64'hB);
        // Flush from FULL drops 0xC
        add(1, 64'hA, 0, 0, 1, 1, 64'hA);
        add(1, 64'hB, 0, 0, 1, 0, 64'hA);
        add(1, 64'hC, 0, 1, 0, 1, RV);
        add(0, 0,     1, 0, 0, 1, RV);
        // Flush from EMPTY drops 0xD even though in_ready=1
        add(1, 64'hD, 1, 1, 0, 1, RV);
        add(0, 0,     1, 0, 0, 1, RV);
        // FULL drain with in_valid held: skid order preserved
        add(1, 64'h1, 0, 0, 1, 1, 64'h1);
        add(1, 64'h2, 0, 0, 1, 0, 64'h1);
        add(1, 64'h3, 1, 0, 1, 1, 64'h2);
        add(1, 64'h3, 1, 0, 1, 1, 64'h3);
        add(0, 0,     1, 0, 0, 1, 64'h3);

        foreach (vecs[i]) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            softReset = vecs[i].sr;
            tick();
            $display("vec %0d: iv=%0b d=%h ordy=%0b sr=%0b -> ov=%0b ir=%0b od=%h",
                     i, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].sr,
                     out_valid, in_ready, out_data);
            chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].ev});
            chk($sformatf("vec%0d_in_ready", i),  {63'd0, in_ready},  {63'd0, vecs[i].er});
            chk($sformatf("vec%0d_out_data", i),  out_data, vecs[i].ed);
        end
        softReset = 1'b0;

        // Async reset mid-stream, between edges
        in_valid = 1'b1; in_data = 64'h77; out_ready = 1'b0;
        tick();
        chk("async_pre_valid", {63'd0, out_valid}, 64'd1);
        in_data = 64'h88;
        #2 reset = 1'b0;
        #1;
        $display("async reset: out_valid=%0b in_ready=%0b out_data=%h", out_valid, in_ready, out_data);
        chk("async_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_in_ready",  {63'd0, in_ready},  64'd1);
        chk("async_out_data",  out_data, RV);
        @(posedge clk); #3;
        chk("async_hold_valid", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        reset = 1'b1;
        tick();
        chk("async_after_valid", {63'd0, out_valid}, 64'd0);
        chk("async_after_data",  out_data, RV);

        // Random valid/ready against a FIFO scoreboard
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 10000; c++) begin
            if (out_valid !== (sb.size() != 0) || in_ready !== (sb.size() != 2)) begin
                chk($sformatf("rnd%0d_occupancy", c), {62'd0, out_valid, in_ready},
                    {62'd0, sb.size() != 0, sb.size() != 2});
            end
            if (prev_stall) begin
                chk($sformatf("rnd%0d_stall_valid", c), {63'd0, out_valid}, 64'd1);
                chk($sformatf("rnd%0d_stall_data", c), out_data, prev_data);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk($sformatf("rnd%0d_unexpected_out", c), out_data, '0);
                end else begin
                    chk($sformatf("rnd%0d_order", c), out_data, sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            tick();
        end
        $display("random: %0d cycles done, %0d in flight", 10000, sb.size());

        // Bounded drain
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8 && out_valid; c++) begin
            chk($sformatf("drain%0d", c), out_data, (sb.size() != 0) ? sb.pop_front() : ~out_data);
            tick();
        end
        chk("drain_empty_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
